barrel_shifter_pipelined: RTL and testbench
===========================================

BARREL_SHIFTER_PIPELINED -- requirements
Module: barrel_shifter_pipelined

Interface
REQ-001 SHALL have parameter N, default 8, data width in bits; legal values are powers of two with N >= 2.
REQ-002 SHALL have derived localparam S = $clog2(N), giving the shift-amount width and the pipeline stage count.
REQ-003 SHALL fail elaboration via $error when N is not a power of two or N < 2.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 flush  input  1  synchronous pipeline clear.
REQ-007 inValid  input  1  input beat present.
REQ-008 inReady  output  1  block accepts an input beat this cycle.
REQ-009 a  input  N  operand.
REQ-010 shiftAmount  input  S  shift distance, 0..N-1.
REQ-011 dir  input  1  direction: 0 = right, 1 = left.
REQ-012 mode  input  2  operation: 00 logical, 01 arithmetic, 10 rotate, 11 reserved.
REQ-013 outValid  output  1  result present.
REQ-014 outReady  input  1  downstream accepts the result.
REQ-015 shifted  output  N  result.

Function
REQ-016 Transfer rules: an input beat is accepted when inValid && inReady; an output beat is consumed when outValid && outReady.
REQ-017 Pipeline structure: S register stages; stage k applies a shift of 2^k when bit k of the beat's shiftAmount is 1, otherwise it passes the data unchanged.
REQ-018 Per-beat control: dir, mode and the remaining shiftAmount bits SHALL travel with each beat through every stage.
REQ-019 Advance condition: advance = !outValid || outReady; all stages SHALL load together when advance = 1 and SHALL hold all contents when advance = 0.
REQ-020 inReady SHALL equal advance && !flush, computed combinationally.
REQ-021 Latency: a beat accepted at edge E SHALL appear on shifted/outValid after edge E+S-1 when no stall occurs (N=8: result visible after the 3rd edge, counting E).
REQ-022 Bubbles: a cycle with no accepted beat SHALL insert a stage-0 valid bit of 0, and bubbles SHALL propagate like data.
REQ-023 Throughput: one beat per cycle when outReady = 1 continuously.
REQ-024 Logical mode: vacated bit positions fill with 0.
REQ-025 Arithmetic mode, right: vacated positions fill with a[N-1].
REQ-026 Arithmetic mode, left: identical to logical left.
REQ-027 Rotate mode: circular shift; bits leaving one end re-enter at the other end.
REQ-028 Mode 11 (reserved) SHALL behave as rotate.
REQ-029 shiftAmount = 0 SHALL return a unchanged in all modes and both directions.
REQ-030 Ordering: beats SHALL leave in acceptance order; none lost or duplicated under any outReady pattern.
REQ-031 Flush = 1 at an edge SHALL clear all stage valid bits, discard any input beat that cycle, and take priority over advance.
REQ-032 shifted is don't-care while outValid = 0; data registers may load on bubbles.

Reset
REQ-033 While rst_n = 0, all stage valid bits SHALL be 0 and all data/control registers SHALL be 0, effective immediately without waiting for clk.
REQ-034 Outputs during and after reset: outValid = 0, shifted = 0, inReady = 1 (when flush = 0).
REQ-035 Reset assertion mid-stream SHALL discard all in-flight beats; the first beat accepted after rst_n rises SHALL emerge after S edges.

Verification (N=8, S=3)
REQ-036 Rotate right: a=0x96, amt=3, dir=0, mode=10 -> shifted=0xD2 after 3 edges; rotate left: a=0x81, amt=1, dir=1 -> 0x03.
REQ-037 Arithmetic/logical: a=0x96, amt=2, dir=0, mode=01 -> 0xE5; a=0x96, amt=1, dir=1, mode=00 -> 0x2C; a=0x96, amt=7, dir=0, mode=00 -> 0x01.
REQ-038 Streaming: 8 back-to-back beats with outReady=1 -> 8 consecutive outValid cycles, correct order, first result at edge 3.
REQ-039 Backpressure: stream beats, hold outReady=0 for 4 cycles mid-stream -> inReady=0 while outValid=1; shifted stable; no beat lost or duplicated; order preserved.
REQ-040 Flush: 3 beats in flight, pulse flush -> outValid=0 next cycle; the input beat presented with flush is not accepted; the next beat's result appears 3 edges after acceptance.
REQ-041 Reset mid-operation: assert rst_n=0 asynchronously between edges with the pipeline full -> outValid=0 and shifted=0 immediately; recovery as in REQ-035.

Source files
------------

// File: rtl/barrel_shifter_pipelined_if.sv
// Purpose: valid/ready operand and result bundle for the pipelined barrel shifter.
// Latency: none; wires only.
// Backpressure: carries inReady upstream and outReady downstream.
interface barrel_shifter_pipelined_if #(
    parameter int N = 8
);
    localparam int S = (N > 1) ? $clog2(N) : 1;

    // Operand side.
    logic         inValid;
    logic         inReady;
    logic [N-1:0] a;
    logic [S-1:0] shiftAmount;
    logic         dir;
    logic [1:0]   mode;

    // Result side.
    logic         outValid;
    logic         outReady;
    logic [N-1:0] shifted;

    // Producer of operands and consumer of results (the environment).
    modport master (
        output inValid,
        output a,
        output shiftAmount,
        output dir,
        output mode,
        output outReady,
        input  inReady,
        input  outValid,
        input  shifted
    );

    // The shifter itself.
    modport slave (
        input  inValid,
        input  a,
        input  shiftAmount,
        input  dir,
        input  mode,
        input  outReady,
        output inReady,
        output outValid,
        output shifted
    );
endinterface

// File: rtl/barrel_shifter_pipelined.sv
// Purpose: log2(N)-stage pipelined shifter/rotator (logical, arithmetic, rotate; left or right).
// Latency: a beat accepted at edge E is presented after edge E+S-1 (S = log2 N stages).
// Backpressure: whole pipe stalls while a result sits unconsumed; inReady = advance && !flush.
module barrel_shifter_pipelined #(
    parameter int N = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    barrel_shifter_pipelined_if.slave bus
);

    localparam int S = $clog2(N);

    // Only power-of-two widths map cleanly onto binary-weighted stages.
    if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
        $error("barrel_shifter_pipelined: N=%0d must be a power of two and at least 2", N);
    end

    // Operation encodings; the reserved code 2'b11 shares the rotate path
    // because only mode[1] is consulted to select rotation.
    localparam logic [1:0] MODE_LOGICAL = 2'b00;
    localparam logic [1:0] MODE_ARITH   = 2'b01;

    // All stages move as one: the pipe advances whenever the output slot
    // is empty or being drained this cycle.
    logic advance;

    // Stage k conditionally shifts by 2^k; control rides along with the data
    // so every beat carries its own direction, mode and distance.
    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int D = 1 << k;

        logic         vld_q,  vld_d;
        logic [N-1:0] dat_q,  dat_d;
        logic [S-1:0] amt_q,  amt_d;
        logic         dir_q,  dir_d;
        logic [1:0]   mode_q, mode_d;

        logic         src_vld;
        logic [N-1:0] src_dat;
        logic [S-1:0] src_amt;
        logic         src_dir;
        logic [1:0]   src_mode;
        logic [N-1:0] shf;

        if (k == 0) begin : g_src
            // First stage is fed straight from the accepted input beat.
            assign src_vld  = bus.inValid;
            assign src_dat  = bus.a;
            assign src_amt  = bus.shiftAmount;
            assign src_dir  = bus.dir;
            assign src_mode = bus.mode;
        end else begin : g_src
            // Later stages take the previous stage's registers.
            assign src_vld  = g_stage[k-1].vld_q;
            assign src_dat  = g_stage[k-1].dat_q;
            assign src_amt  = g_stage[k-1].amt_q;
            assign src_dir  = g_stage[k-1].dir_q;
            assign src_mode = g_stage[k-1].mode_q;
        end

        // Shift by this stage's fixed weight when the beat's distance bit k is set.
        always_comb begin
            shf = src_dat;
            if (src_amt[k]) begin
                if (src_dir) begin
                    if (src_mode[1]) begin
                        shf = (src_dat << D) | (src_dat >> (N - D));
                    end else begin
                        // Arithmetic left is the same as logical left.
                        shf = src_dat << D;
                    end
                end else begin
                    if (src_mode[1]) begin
                        shf = (src_dat >> D) | (src_dat << (N - D));
                    end else if (src_mode == MODE_ARITH) begin
                        // Sign bit survives each partial shift, so replicating
                        // the current MSB per stage equals replicating a[N-1].
                        shf = $unsigned($signed(src_dat) >>> D);
                    end else begin
                        shf = src_dat >> D;
                    end
                end
            end
        end

        // Next-state: flush clears validity and wins over advance; otherwise
        // load on advance (bubbles included) and hold on stall.
        always_comb begin
            vld_d  = vld_q;
            dat_d  = dat_q;
            amt_d  = amt_q;
            dir_d  = dir_q;
            mode_d = mode_q;
            if (flush) begin
                vld_d = 1'b0;
            end else if (advance) begin
                vld_d  = src_vld;
                dat_d  = shf;
                amt_d  = src_amt;
                dir_d  = src_dir;
                mode_d = src_mode;
            end
        end

        // Stage registers; reset clears contents immediately, independent of clk.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                dat_q  <= '0;
                amt_q  <= '0;
                dir_q  <= 1'b0;
                mode_q <= MODE_LOGICAL;
            end else begin
                vld_q  <= vld_d;
                dat_q  <= dat_d;
                amt_q  <= amt_d;
                dir_q  <= dir_d;
                mode_q <= mode_d;
            end
        end
    end

    assign advance      = !g_stage[S-1].vld_q || bus.outReady;
    assign bus.inReady  = advance && !flush;
    assign bus.outValid = g_stage[S-1].vld_q;
    assign bus.shifted  = g_stage[S-1].dat_q;

    // The last stage's control copies have no consumer beyond the pipe end.
    logic ctl_unused;
    assign ctl_unused = ^{g_stage[S-1].amt_q, g_stage[S-1].dir_q, g_stage[S-1].mode_q};

endmodule

// File: tb/tb_barrel_shifter_pipelined.sv
// Purpose: directed self-checking bench for barrel_shifter_pipelined at N=8.
// Latency: expects results after the third edge counting acceptance.
// Backpressure: exercises stalls, flush and asynchronous reset mid-stream.
module tb_barrel_shifter_pipelined;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    barrel_shifter_pipelined_if #(.N(N)) bus ();

    barrel_shifter_pipelined #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] av, input logic [2:0] amt,
                         input logic d, input logic [1:0] m);
        bus.inValid     = 1'b1;
        bus.a           = av;
        bus.shiftAmount = amt;
        bus.dir         = d;
        bus.mode        = m;
    endtask

    // One isolated beat: accept at edge E, nothing after E+1, result after E+2.
    task automatic single(input string tag, input logic [7:0] av, input logic [2:0] amt,
                          input logic d, input logic [1:0] m, input logic [7:0] exp);
        drive(av, amt, d, m);
        step();
        bus.inValid = 1'b0;
        step();
        chk({tag, "_early"}, 16'(bus.outValid), 16'd0);
        step();
        chk({tag, "_vld"}, 16'(bus.outValid), 16'd1);
        chk(tag, 16'(bus.shifted), 16'(exp));
        step();
    endtask

    logic [7:0] q[$];
    logic [7:0] prev_dat;
    logic       stall_prev;
    int         sent;
    int         got;

    initial begin
        rst_n           = 1'b1;
        flush           = 1'b0;
        bus.inValid     = 1'b0;
        bus.a           = '0;
        bus.shiftAmount = '0;
        bus.dir         = 1'b0;
        bus.mode        = 2'b00;
        bus.outReady    = 1'b1;

        // Reset takes effect without any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_outvalid", 16'(bus.outValid), 16'd0);
        chk("rst_shifted",  16'(bus.shifted),  16'd0);
        chk("rst_inready",  16'(bus.inReady),  16'd1);
        #20 rst_n = 1'b1;
        step();

        // Directed single beats.
        single("rotr3",      8'h96, 3'd3, 1'b0, 2'b10, 8'hD2);
        single("rotl1",      8'h81, 3'd1, 1'b1, 2'b10, 8'h03);
        single("asr2",       8'h96, 3'd2, 1'b0, 2'b01, 8'hE5);
        single("lsl1",       8'h96, 3'd1, 1'b1, 2'b00, 8'h2C);
        single("lsr7",       8'h96, 3'd7, 1'b0, 2'b00, 8'h01);
        single("amt0_rotl",  8'h96, 3'd0, 1'b1, 2'b10, 8'h96);
        single("amt0_asr",   8'h96, 3'd0, 1'b0, 2'b01, 8'h96);
        single("asl2",       8'h96, 3'd2, 1'b1, 2'b01, 8'h58);
        single("rsv_rotr3",  8'h96, 3'd3, 1'b0, 2'b11, 8'hD2);
        single("rsv_rotl2",  8'h96, 3'd2, 1'b1, 2'b11, 8'h5A);
        single("lsr3",       8'h96, 3'd3, 1'b0, 2'b00, 8'h12);
        single("asr7",       8'h96, 3'd7, 1'b0, 2'b01, 8'hFF);
        single("asr1_pos",   8'h46, 3'd1, 1'b0, 2'b01, 8'h23);
        single("lsr4",       8'hF0, 3'd4, 1'b0, 2'b00, 8'h0F);

        // Streaming: 8 back-to-back beats, rotate left by 4 swaps nibbles.
        for (int i = 0; i < 8; i++) begin
            drive({4'(i), 4'hC}, 3'd4, 1'b1, 2'b10);
            #1;
            chk("stream_inready", 16'(bus.inReady), 16'd1);
            step();
            if (i >= 2) begin
                chk("stream_vld", 16'(bus.outValid), 16'd1);
                chk("stream_dat", 16'(bus.shifted), 16'({4'hC, 4'(i - 2)}));
            end
        end
        bus.inValid = 1'b0;
        for (int j = 6; j < 8; j++) begin
            step();
            chk("stream_tail_vld", 16'(bus.outValid), 16'd1);
            chk("stream_tail_dat", 16'(bus.shifted), 16'({4'hC, 4'(j)}));
        end
        step();
        chk("stream_end", 16'(bus.outValid), 16'd0);

        // Backpressure: outReady low for 4 cycles mid-stream; scoreboard order.
        sent       = 0;
        got        = 0;
        stall_prev = 1'b0;
        prev_dat   = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            bus.inValid     = (sent < 8);
            bus.a           = {4'(sent), 4'h3};
            bus.shiftAmount = 3'd4;
            bus.dir         = 1'b0;
            bus.mode        = 2'b11;
            bus.outReady    = !(c >= 5 && c < 9);
            #1;
            if (bus.outValid && !bus.outReady) begin
                chk("bp_inready", 16'(bus.inReady), 16'd0);
                if (stall_prev) chk("bp_stable", 16'(bus.shifted), 16'(prev_dat));
            end
            if (bus.inValid && bus.inReady) begin
                q.push_back({4'h3, 4'(sent)});
                sent++;
            end
            if (bus.outValid && bus.outReady) begin
                if (q.size() > 0) chk("bp_order", 16'(bus.shifted), 16'(q.pop_front()));
                else chk("bp_extra_beat", 16'(bus.shifted), 16'hFFFF);
                got++;
            end
            stall_prev = bus.outValid && !bus.outReady;
            prev_dat   = bus.shifted;
            step();
        end
        chk("bp_count",   16'(got),      16'd8);
        chk("bp_leftover", 16'(q.size()), 16'd0);
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        step();

        // Flush with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            drive({4'h1, 4'(i)}, 3'd0, 1'b0, 2'b00);
            step();
        end
        drive(8'hEE, 3'd1, 1'b1, 2'b00);
        flush = 1'b1;
        #1;
        chk("fl_pre_vld", 16'(bus.outValid), 16'd1);
        chk("fl_inready", 16'(bus.inReady),  16'd0);
        step();
        flush       = 1'b0;
        bus.inValid = 1'b0;
        chk("fl_outvalid", 16'(bus.outValid), 16'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_drained", 16'(bus.outValid), 16'd0);
        end
        single("fl_next", 8'h96, 3'd1, 1'b0, 2'b00, 8'h4B);

        // Asynchronous reset with the pipeline full.
        for (int i = 0; i < 3; i++) begin
            drive({4'h7, 4'(i)}, 3'd0, 1'b0, 2'b00);
            step();
        end
        drive(8'h55, 3'd0, 1'b0, 2'b00);
        #3 rst_n = 1'b0;
        #1;
        chk("rs_outvalid", 16'(bus.outValid), 16'd0);
        chk("rs_shifted",  16'(bus.shifted),  16'd0);
        chk("rs_inready",  16'(bus.inReady),  16'd1);
        bus.inValid = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rs_drained", 16'(bus.outValid), 16'd0);
        end
        single("rs_next", 8'h96, 3'd7, 1'b0, 2'b01, 8'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
